// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit memory master.
// Contents:
//   XLEN          - data/address width (only 32 is supported)
//   F3_*          - RV32I load/store funct3 encodings
//   lsu_state_e   - state encoding of the request FSM
package riscv_lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational byte-lane logic for the load/store unit.
// Ports:
//   we_i          - 1 = store, 0 = load
//   funct3_i      - RV32I funct3 (access size and sign)
//   addr_lo_i     - byte offset within the word
//   mem_word_i    - word read from the data memory
//   store_data_i  - right-justified store data
//   load_data_o   - lane extracted from mem_word_i and sign/zero extended
//   store_word_o  - mem_word_i with the store lane replaced by store_data_i
//   err_o         - illegal funct3 or (when ALIGN_CHECK) misaligned access
module lsu_lane_align
    import riscv_lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] mem_word_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] store_word_o,
    output logic            err_o
);

    logic [4:0]      byte_shift;
    logic [4:0]      half_shift;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] half_mask;
    logic            illegal;
    logic            misaligned;

    // Halfwords are selected by addr[1] only, so with the alignment check
    // disabled an odd halfword address silently falls back to its aligned lane.
    assign byte_shift = {addr_lo_i, 3'b000};
    assign half_shift = {addr_lo_i[1], 4'b0000};
    assign lane_b     = 8'(mem_word_i >> byte_shift);
    assign lane_h     = 16'(mem_word_i >> half_shift);
    assign byte_mask  = 32'h0000_00FF << byte_shift;
    assign half_mask  = 32'h0000_FFFF << half_shift;

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data_o = {24'h0, lane_b};
            F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data_o = {16'h0, lane_h};
            F3_W:    load_data_o = mem_word_i;
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        store_word_o = mem_word_i;
        case (funct3_i)
            F3_B:    store_word_o = (mem_word_i & ~byte_mask) |
                                    ((store_data_i & 32'h0000_00FF) << byte_shift);
            F3_H:    store_word_o = (mem_word_i & ~half_mask) |
                                    ((store_data_i & 32'h0000_FFFF) << half_shift);
            F3_W:    store_word_o = store_data_i;
            default: store_word_o = mem_word_i;
        endcase
    end

    // Stores only have B/H/W; loads additionally allow BU/HU.
    always_comb begin
        if (we_i) begin
            illegal = (funct3_i > F3_W);
        end else begin
            illegal = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
        end
        misaligned = ALIGN_CHECK &&
                     (((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00)));
        err_o = illegal || misaligned;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core execute stage and a word-organised
// data memory with combinational read and clocked write.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - request handshake (ready only in IDLE)
//   req_we/req_funct3          - store flag and RV32I access size/sign
//   req_addr/req_wdata         - byte address, right-justified store data
//   resp_valid                 - one-cycle completion pulse
//   resp_rdata/resp_err        - extended load result / error flag
//   mem_addr/mem_wdata/mem_we  - word memory write port and read address
//   mem_rdata                  - combinational read word
// Sub-word stores are done as read-modify-write: READ captures the merged
// word, WRITE drives it for exactly one cycle.
module lsu_mem_master #(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    import riscv_lsu_pkg::*;

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            in_idle;
    logic            al_we;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_load;
    logic [XLEN-1:0] al_store;
    logic            al_err;

    // One lane aligner serves both phases: in IDLE it checks the incoming
    // request for errors, afterwards it works on the latched request.
    assign in_idle    = (state_q == IDLE);
    assign al_we      = in_idle ? req_we     : we_q;
    assign al_funct3  = in_idle ? req_funct3 : funct3_q;
    assign al_addr_lo = in_idle ? req_addr[1:0] : addr_lo_q;
    assign al_wdata   = in_idle ? req_wdata  : wdata_q;

    lsu_lane_align #(
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_align (
        .we_i         (al_we),
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .mem_word_i   (mem_rdata),
        .store_data_i (al_wdata),
        .load_data_o  (al_load),
        .store_word_o (al_store),
        .err_o        (al_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Errored requests leave mem_addr/mem_wdata untouched and go straight to
    // RESP. SW needs no read, so its word is loaded on accept.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    rdata_d   = '0;
                    err_d     = al_err;
                    if (al_err) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_wdata_d = req_wdata;
                            state_d     = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    mem_wdata_d = al_store;
                    state_d     = WRITE;
                end else begin
                    rdata_d = al_load;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_we is decoded from the state register so an asynchronous reset
    // drops it immediately, before any write edge.
    assign req_ready  = in_idle;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = (state_q == WRITE);

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset and
// back-to-back sequences, and randomized traffic against a reference model.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] dutMem [0:255];
    logic [31:0] refMem [0:255];
    logic        loadEn;
    logic [7:0]  loadIdx;
    logic [31:0] loadData;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    lsu_mem_master #(
        .XLEN        (32),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT: combinational read, write on rising edge.
    assign mem_rdata = dutMem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (loadEn) dutMem[loadIdx] <= loadData;
        else if (mem_we) dutMem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: RV32I load/store semantics on a word array.
    task automatic modelOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] expRdata,
                           output logic expErr, output int expLat, output int expWeCycle);
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        logic        illegal;
        logic        mis;
        int          sz;
        int          sh;
        word = refMem[addr[9:2]];
        sz = int'(f3 & 3'd3);
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
        expErr = illegal || mis;
        expRdata = 32'h0;
        expWeCycle = 0;
        sh = (sz == 0) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
        if (expErr) begin
            expLat = 1;
        end else if (!we) begin
            expLat = 2;
            v = word >> sh;
            case (f3)
                3'd0:    expRdata = int'(byte'(v));
                3'd1:    expRdata = int'(shortint'(v));
                3'd4:    expRdata = v & 32'hFF;
                3'd5:    expRdata = v & 32'hFFFF;
                default: expRdata = word;
            endcase
        end else if (f3 == 3'd2) begin
            expLat = 2;
            expWeCycle = 1;
            refMem[addr[9:2]] = wdata;
        end else begin
            expLat = 3;
            expWeCycle = 2;
            mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
            refMem[addr[9:2]] = (word & ~mask) | ((wdata << sh) & mask);
        end
    endtask

    // Issue one request and watch the DUT until the response (bounded).
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] gotRdata,
                                 output logic gotErr, output int gotLat, output int weCycle,
                                 output int weCount, output logic [31:0] weAddr, output int readyHigh);
        int guard;
        gotRdata = 32'h0; gotErr = 1'b0; gotLat = 0;
        weCycle = 0; weCount = 0; weAddr = 32'h0; readyHigh = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            gotLat = -1;
            return;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            if (mem_we) begin
                weCount++;
                weCycle = cyc;
                weAddr = mem_addr;
            end
            if (req_ready) readyHigh++;
            if (resp_valid) begin
                gotRdata = resp_rdata;
                gotErr = resp_err;
                gotLat = cyc;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] gotRdata, output logic gotErr, output int gotLat);
        logic [31:0] expRdata, weAddr;
        logic        expErr;
        int          expLat, expWeCycle, weCycle, weCount, readyHigh;
        modelOp(we, f3, addr, wdata, expRdata, expErr, expLat, expWeCycle);
        applyStimulus(we, f3, addr, wdata, gotRdata, gotErr, gotLat, weCycle, weCount, weAddr, readyHigh);
        checkOutput({name, "_rdata"}, gotRdata, expRdata);
        checkOutput({name, "_err"}, 32'(gotErr), 32'(expErr));
        checkOutput({name, "_latency"}, gotLat, expLat);
        checkOutput({name, "_we_pulses"}, weCount, (expWeCycle != 0) ? 1 : 0);
        checkOutput({name, "_we_cycle"}, weCycle, expWeCycle);
        if (expWeCycle != 0) checkOutput({name, "_we_addr"}, weAddr, {addr[31:2], 2'b00});
        checkOutput({name, "_ready_low"}, readyHigh, 0);
        checkOutput({name, "_memword"}, dutMem[addr[9:2]], refMem[addr[9:2]]);
    endtask

    initial begin
        logic [31:0] gotRdata;
        logic        gotErr;
        int          gotLat;
        logic [31:0] bbRdata [3];
        logic        bbErr [3];
        int          bbLat;
        logic        bbWe [3];
        logic [2:0]  bbF3 [3];
        logic [31:0] bbAddr [3];
        logic [31:0] bbWdata [3];
        logic [31:0] gotR[$];
        logic        gotE[$];
        logic [31:0] wordBefore;
        logic        acceptNext;
        int          idx, bbWeCycle;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; loadEn = 1'b1; loadIdx = 8'h0; loadData = 32'h0;

        // Preload both memories while the DUT is held in reset.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i == 4) v = 32'h807F_C3A1;
            if (i == 8) v = 32'h1122_3344;
            loadIdx = 8'(i);
            loadData = v;
            refMem[i] = v;
            @(posedge clk);
            #1;
        end
        loadEn = 1'b0;

        checkOutput("reset_ready", 32'(req_ready), 32'h1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset_resp_err", 32'(resp_err), 32'h0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{1'b0, 3'd0, 32'h10, 32'h0,         32'hFFFF_FFA1, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd4, 32'h11, 32'h0,         32'h0000_00C3, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd1, 32'h12, 32'h0,         32'hFFFF_807F, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd5, 32'h12, 32'h0,         32'h0000_807F, 1'b0, 2});
        vecs.push_back('{1'b1, 3'd0, 32'h22, 32'hAB,        32'h0,         1'b0, 3});
        vecs.push_back('{1'b0, 3'd2, 32'h20, 32'h0,         32'h11AB_3344, 1'b0, 2});
        vecs.push_back('{1'b1, 3'd2, 32'h24, 32'hDEAD_BEEF, 32'h0,         1'b0, 2});
        vecs.push_back('{1'b0, 3'd2, 32'h24, 32'h0,         32'hDEAD_BEEF, 1'b0, 2});
        vecs.push_back('{1'b0, 3'd2, 32'h26, 32'h0,         32'h0,         1'b1, 1});
        vecs.push_back('{1'b1, 3'd1, 32'h31, 32'h1234,      32'h0,         1'b1, 1});
        vecs.push_back('{1'b0, 3'd3, 32'h20, 32'h0,         32'h0,         1'b1, 1});
        vecs.push_back('{1'b1, 3'd1, 32'h22, 32'h5566,      32'h0,         1'b0, 3});
        vecs.push_back('{1'b0, 3'd2, 32'h20, 32'h0,         32'h5566_3344, 1'b0, 2});
        vecs.push_back('{1'b1, 3'd4, 32'h20, 32'h99,        32'h0,         1'b1, 1});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            runOp(nm, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, gotRdata, gotErr, gotLat);
            checkOutput({nm, "_tbl_rdata"}, gotRdata, vecs[i].expRdata);
            checkOutput({nm, "_tbl_err"}, 32'(gotErr), 32'(vecs[i].expErr));
            checkOutput({nm, "_tbl_latency"}, gotLat, vecs[i].expLat);
        end

        // Reset asserted while an SH read-modify-write is in READ.
        wordBefore = dutMem[8'h0A];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h2A; req_wdata = 32'h5566;
        @(posedge clk);
        #2;
        checkOutput("rst_in_read_busy", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_after", 32'(req_ready), 32'h1);
        checkOutput("rst_mem_we_after", 32'(mem_we), 32'h0);
        checkOutput("rst_word_unchanged", dutMem[8'h0A], wordBefore);
        checkOutput("rst_word_model", dutMem[8'h0A], refMem[8'h0A]);

        // Back-to-back load/store/load with req_valid held high.
        bbWe[0] = 1'b0; bbF3[0] = 3'd2; bbAddr[0] = 32'h10; bbWdata[0] = 32'h0;
        bbWe[1] = 1'b1; bbF3[1] = 3'd2; bbAddr[1] = 32'h30; bbWdata[1] = 32'h1234_5678;
        bbWe[2] = 1'b0; bbF3[2] = 3'd1; bbAddr[2] = 32'h32; bbWdata[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            modelOp(bbWe[i], bbF3[i], bbAddr[i], bbWdata[i], bbRdata[i], bbErr[i], bbLat, bbWeCycle);
        end
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                gotR.push_back(resp_rdata);
                gotE.push_back(resp_err);
                checkOutput("b2b_ready_in_resp", 32'(req_ready), 32'h0);
            end
            if (idx < 3) begin
                req_valid = 1'b1; req_we = bbWe[idx]; req_funct3 = bbF3[idx];
                req_addr = bbAddr[idx]; req_wdata = bbWdata[idx];
            end else begin
                req_valid = 1'b0;
            end
            acceptNext = req_ready && (idx < 3);
            @(posedge clk);
            if (acceptNext) idx++;
        end
        checkOutput("b2b_accepts", idx, 3);
        checkOutput("b2b_responses", gotR.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < gotR.size()) begin
                checkOutput($sformatf("b2b_rdata%0d", i), gotR[i], bbRdata[i]);
                checkOutput($sformatf("b2b_err%0d", i), 32'(gotE[i]), 32'(bbErr[i]));
            end
        end
        checkOutput("b2b_memword", dutMem[8'h0C], refMem[8'h0C]);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 120; i++) begin
            runOp($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, gotRdata, gotErr, gotLat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
